// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one external SRAM between the AVR and SNES ports and
// owns all SRAM strobe timing (IDLE -> SETUP -> ACCESS x WAIT_CYCLES -> DONE).
// Optional feature: define SRAM_ARB_AUTOINC_EN to pulse avr_counter_inc with
// every AVR ack; otherwise avr_counter_inc stays 0.
module sram_arbiter #(
    parameter int ADDR_W      = 21,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              avr_clk,
    input  logic              avr_reset_n,
    input  logic              avr_snes_mode,
    input  logic              avr_req,
    input  logic              avr_rw,
    input  logic [ADDR_W-1:0] avr_addr,
    input  logic [DATA_W-1:0] avr_wdata,
    output logic [DATA_W-1:0] avr_rdata,
    output logic              avr_ack,
    output logic              avr_counter_inc,
    input  logic              snes_req,
    input  logic              snes_rw,
    input  logic [ADDR_W-1:0] snes_addr,
    input  logic [DATA_W-1:0] snes_wdata,
    output logic [DATA_W-1:0] snes_rdata,
    output logic              snes_ack,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dout,
    output logic              sram_dout_en,
    input  logic [DATA_W-1:0] sram_din,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam logic       OWN_AVR   = 1'b0;
    localparam logic       OWN_SNES  = 1'b1;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t     state, state_d;
    logic [3:0] cnt;
    logic       owner, rw_q, last_grant;
    logic       grant, grant_snes, last_cycle;
    logic       owner_d, rw_d;
    logic       ce_n_d, oe_n_d, we_n_d, dout_en_d;

    // Arbitration; owner_d/rw_d describe the access the next cycle belongs to
    always_comb begin
        grant      = avr_req | snes_req;
        grant_snes = snes_req & (~avr_req | avr_snes_mode | (last_grant == OWN_AVR));
        last_cycle = (state == ACCESS) && (cnt == 4'd0);
        owner_d    = owner;
        rw_d       = rw_q;
        if (state == IDLE && grant) begin
            owner_d = grant_snes;
            rw_d    = grant_snes ? snes_rw : avr_rw;
        end
    end

    // State register
    always_ff @(posedge avr_clk or negedge avr_reset_n) begin
        if (!avr_reset_n) state <= IDLE;
        else              state <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (grant) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (cnt == 4'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the granted request and run the strobe-width counter
    always_ff @(posedge avr_clk or negedge avr_reset_n) begin
        if (!avr_reset_n) begin
            cnt        <= 4'd0;
            owner      <= OWN_AVR;
            rw_q       <= 1'b1;
            last_grant <= OWN_SNES;
            sram_addr  <= '0;
            sram_dout  <= '0;
        end else begin
            if (state == IDLE && grant) begin
                owner      <= owner_d;
                rw_q       <= rw_d;
                last_grant <= grant_snes;
                sram_addr  <= grant_snes ? snes_addr : avr_addr;
                if (!rw_d) sram_dout <= grant_snes ? snes_wdata : avr_wdata;
            end
            if (state == SETUP)
                cnt <= WAIT_LOAD;
            else if (state == ACCESS && cnt != 4'd0)
                cnt <= cnt - 4'd1;
        end
    end

    // Pin values for the coming cycle; OE and WE are mutually exclusive by rw
    always_comb begin
        ce_n_d    = (state_d == IDLE);
        oe_n_d    = !((state_d == ACCESS) && rw_d);
        we_n_d    = !((state_d == ACCESS) && !rw_d);
        dout_en_d = (state_d != IDLE) && !rw_d;
    end

    // Registered outputs: strobes, acks, read-data capture at end of ACCESS
    always_ff @(posedge avr_clk or negedge avr_reset_n) begin
        if (!avr_reset_n) begin
            sram_ce_n       <= 1'b1;
            sram_oe_n       <= 1'b1;
            sram_we_n       <= 1'b1;
            sram_dout_en    <= 1'b0;
            avr_ack         <= 1'b0;
            snes_ack        <= 1'b0;
            avr_rdata       <= '0;
            snes_rdata      <= '0;
            avr_counter_inc <= 1'b0;
        end else begin
            sram_ce_n    <= ce_n_d;
            sram_oe_n    <= oe_n_d;
            sram_we_n    <= we_n_d;
            sram_dout_en <= dout_en_d;
            avr_ack      <= last_cycle && (owner == OWN_AVR);
            snes_ack     <= last_cycle && (owner == OWN_SNES);
            if (last_cycle && rw_q) begin
                if (owner == OWN_AVR) avr_rdata  <= sram_din;
                else                  snes_rdata <= sram_din;
            end
`ifdef SRAM_ARB_AUTOINC_EN
            avr_counter_inc <= last_cycle && (owner == OWN_AVR);
`else
            avr_counter_inc <= 1'b0;
`endif
        end
    end
endmodule
